// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl
// Word-stream front end for aes_cipher_top. Packs four big-endian 32-bit
// plaintext words into a block, pulses aes_ld with the latched key, waits for
// aes_done under a watchdog, then drains the captured ciphertext as four
// 32-bit words over a valid/ready port. Only one block is in flight at a time.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FILL  | accepting plaintext words; in_ready=1; in_cnt words held
// ST_LOAD  | single cycle with aes_ld=1; block and key presented to cipher
// ST_WAIT  | waiting for aes_done; watchdog counting down
// ST_DRAIN | out_valid=1; streaming captured ciphertext words 0..3
module aes_stream_ctrl #(
  // Cycles allowed from the aes_ld cycle until err; must be >= 16.
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text_in,
  input  logic [127:0] aes_text_out,
  input  logic         aes_done,
  output logic         busy,
  output logic         err,
  output logic [15:0]  blk_cnt
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // The watchdog is a down-counter reloaded on the LOAD edge. With a reload
  // of TIMEOUT-1 and a terminal count of 1, the expiry edge is the one that
  // ends the (TIMEOUT-1)th WAIT cycle, so err is first seen exactly TIMEOUT
  // cycles after the cycle in which aes_ld was high.
  localparam int unsigned     WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(1);

  state_t            state;
  logic [1:0]        in_cnt;
  logic [1:0]        out_idx;
  logic [95:0]       fill_buf;
  logic [127:0]      out_buf;
  logic [WD_W-1:0]   wd_cnt;

  // Big-endian word select: index 0 is the most significant word.
  function automatic logic [31:0] word_sel(input logic [127:0] blk,
                                           input logic [1:0]   idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  // Idle only when sitting in FILL with no partial block collected.
  assign busy = !((state == ST_FILL) && (in_cnt == 2'd0));

  // Sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_FILL;
      in_cnt      <= 2'd0;
      out_idx     <= 2'd0;
      fill_buf    <= '0;
      out_buf     <= '0;
      wd_cnt      <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      aes_ld      <= 1'b0;
      aes_key     <= '0;
      aes_text_in <= '0;
      err         <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      aes_ld <= 1'b0;
      case (state)
        ST_FILL: begin
          if (in_valid && in_ready) begin
            if (in_cnt == 2'd3) begin
              // Cipher inputs only change here, so they stay frozen from
              // LOAD through WAIT, DRAIN and any partial refill.
              aes_text_in <= {fill_buf, in_data};
              aes_key     <= key;
              aes_ld      <= 1'b1;
              in_ready    <= 1'b0;
              in_cnt      <= 2'd0;
              state       <= ST_LOAD;
            end else begin
              fill_buf <= {fill_buf[63:0], in_data};
              in_cnt   <= in_cnt + 2'd1;
            end
          end
        end

        ST_LOAD: begin
          wd_cnt <= WD_LOAD;
          state  <= ST_WAIT;
        end

        ST_WAIT: begin
          // Completion is tested first so a done on the expiry edge wins.
          if (aes_done) begin
            out_buf   <= aes_text_out;
            out_data  <= aes_text_out[127:96];
            out_valid <= 1'b1;
            out_idx   <= 2'd0;
            state     <= ST_DRAIN;
          end else if (wd_cnt == WD_LAST) begin
            err      <= 1'b1;
            in_ready <= 1'b1;
            state    <= ST_FILL;
          end else begin
            wd_cnt <= wd_cnt - WD_LAST;
          end
        end

        ST_DRAIN: begin
          if (out_ready) begin
            if (out_idx == 2'd3) begin
              out_valid <= 1'b0;
              blk_cnt   <= blk_cnt + 16'd1;
              in_ready  <= 1'b1;
              state     <= ST_FILL;
            end else begin
              out_idx  <= out_idx + 2'd1;
              out_data <= word_sel(out_buf, out_idx + 2'd1);
            end
          end
        end

        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          in_cnt    <= 2'd0;
          state     <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: a behavioural cipher stand-in plus a queue-based
// model of the expected ciphertext word stream and drained-block count.
`timescale 1ns/1ps
module tb_aes_stream_ctrl;

  localparam int TIMEOUT = 64;

  localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_ECB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_ECB  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_ECB  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         aes_ld;
  logic [127:0] aes_key;
  logic [127:0] aes_text_in;
  logic [127:0] aes_text_out;
  logic         aes_done;
  logic         busy;
  logic         err;
  logic [15:0]  blk_cnt;

  always #5 clk = ~clk;

  aes_stream_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key(key), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .aes_ld(aes_ld), .aes_key(aes_key),
    .aes_text_in(aes_text_in), .aes_text_out(aes_text_out),
    .aes_done(aes_done), .busy(busy), .err(err), .blk_cnt(blk_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Cipher stand-in: real answers for the published vectors, an arbitrary
  // fixed mixing function otherwise.
  function automatic logic [127:0] cipher_fn(input logic [127:0] k,
                                             input logic [127:0] p);
    if (k == K_FIPS && p == P_FIPS) return C_FIPS;
    if (k == K_ECB && p == P_ECB) return C_ECB;
    return {p[95:0], p[127:96]} ^ {k[63:0], k[127:64]} ^
           128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Reference model state
  logic [31:0]  exp_q[$];
  logic [127:0] cm_key_q[$];
  logic [127:0] cm_pt_q[$];
  logic [127:0] s_key[$];
  logic [127:0] s_pt[$];
  logic [127:0] s_ct[$];
  logic [15:0]  blk_exp = '0;

  int           cm_lat  = 8;
  bit           cm_dead = 1'b0;
  bit           cm_rand = 1'b0;
  bit           cm_pend = 1'b0;
  int           cm_cnt  = 0;
  int           ld_run  = 0;
  logic [127:0] cm_res;

  // Cipher model: answers aes_ld after cm_lat cycles, noise on text_out otherwise.
  initial begin : cipher_model
    logic [127:0] ek, ep;
    aes_done = 1'b0;
    aes_text_out = '0;
    forever begin
      @(posedge clk); #1;
      aes_done = 1'b0;
      aes_text_out = {$urandom, $urandom, $urandom, $urandom};
      if (!rst) begin
        cm_pend = 1'b0;
        ld_run = 0;
      end else begin
        if (cm_pend) begin
          cm_cnt--;
          if (cm_cnt <= 0) begin
            aes_done = 1'b1;
            aes_text_out = cm_res;
            cm_pend = 1'b0;
          end
        end
        if (aes_ld === 1'b1) begin
          ld_run++;
          if (ld_run == 1) begin
            check("in_ready_at_ld", in_ready, 0);
            check("ld_expected", cm_key_q.size() > 0, 1);
            if (cm_key_q.size() > 0) begin
              ek = cm_key_q.pop_front();
              ep = cm_pt_q.pop_front();
              check("aes_key", aes_key, ek);
              check("aes_text_in", aes_text_in, ep);
              if (!cm_dead) begin
                cm_pend = 1'b1;
                cm_cnt = cm_rand ? int'($urandom_range(1, 30)) : cm_lat;
                cm_res = cipher_fn(ek, ep);
              end
            end
          end
        end else if (ld_run > 0) begin
          check("aes_ld_width", ld_run, 1);
          ld_run = 0;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_aes_ld"}, aes_ld, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_aes_key"}, aes_key, 0);
    check({tag, "_aes_text_in"}, aes_text_in, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_blk_cnt"}, blk_cnt, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_zero(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    blk_exp = '0;
    exp_q.delete();
    cm_key_q.delete();
    cm_pt_q.delete();
  endtask

  // Present words w_lo..w_hi of block p; key is only valid alongside word 3.
  task automatic feed_words(input logic [127:0] k, input logic [127:0] p,
                            input int gap_pct, input int w_lo, input int w_hi);
    for (int w = w_lo; w <= w_hi; w++) begin
      int waited = 0;
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      key = (w == 3) ? k : {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      in_data = p[127 - 32*w -: 32];
      while (in_ready !== 1'b1) begin
        @(posedge clk); #1;
        waited++;
        if (waited > 2000) begin
          n_checks++;
          n_fail++;
          $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, required 1", in_ready, waited);
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Accept nwords output words with random stalls, checking against exp_q.
  task automatic drain(input int nwords, input int stall_pct);
    int got = 0;
    int cycles = 0;
    bit stalled = 1'b0;
    bit hs = 1'b0;
    logic [31:0] held = '0;
    while (got < nwords) begin
      if (stalled) begin
        check("out_valid_held", out_valid, 1);
        check("out_data_stable", out_data, held);
      end
      stalled = 1'b0;
      hs = 1'b0;
      out_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
      if (out_valid === 1'b1) begin
        check("in_ready_drain", in_ready, 0);
        if (out_ready) begin
          check($sformatf("out_word%0d", got % 4), out_data, exp_q.pop_front());
          got++;
          hs = 1'b1;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
      @(posedge clk); #1;
      cycles++;
      if (hs && (got % 4 == 0)) begin
        check("out_valid_after_block", out_valid, 0);
        check("in_ready_after_block", in_ready, 1);
        blk_exp = blk_exp + 16'd1;
        check("blk_cnt", blk_cnt, blk_exp);
      end
      if (cycles > 4000) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_wait: %0d of %0d words after %0d cycles", got, nwords, cycles);
        out_ready = 1'b0;
        return;
      end
    end
    out_ready = 1'b0;
  endtask

  // Stream the blocks queued in s_key/s_pt/s_ct through the DUT.
  task automatic run_stream(input int gap_pct, input int stall_pct);
    int nblk = s_key.size();
    for (int b = 0; b < nblk; b++) begin
      logic [127:0] c = s_ct[b];
      cm_key_q.push_back(s_key[b]);
      cm_pt_q.push_back(s_pt[b]);
      for (int w = 0; w < 4; w++) exp_q.push_back(c[127 - 32*w -: 32]);
    end
    fork
      begin
        for (int b = 0; b < nblk; b++) feed_words(s_key[b], s_pt[b], gap_pct, 0, 3);
      end
      drain(4 * nblk, stall_pct);
    join
    s_key.delete();
    s_pt.delete();
    s_ct.delete();
  endtask

  task automatic queue_block(input logic [127:0] k, input logic [127:0] p,
                             input logic [127:0] c);
    s_key.push_back(k);
    s_pt.push_back(p);
    s_ct.push_back(c);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           gap_pct;
    int           stall_pct;
  } vec_t;

  initial begin : time_limit
    #500000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs [4];
    int   n;
    logic [127:0] rk, rp;

    in_valid = 1'b0;
    in_data = '0;
    key = '0;
    out_ready = 1'b0;
    #1 rst = 1'b0;

    vecs[0] = '{K_FIPS, P_FIPS, C_FIPS, 0, 0};
    vecs[1] = '{K_ECB, P_ECB, C_ECB, 40, 40};
    vecs[2] = '{128'hdeadbeef_01234567_89abcdef_fedcba98,
                128'h11111111_22222222_33333333_44444444,
                cipher_fn(128'hdeadbeef_01234567_89abcdef_fedcba98,
                          128'h11111111_22222222_33333333_44444444), 0, 60};
    vecs[3] = '{128'h0, {128{1'b1}}, cipher_fn(128'h0, {128{1'b1}}), 25, 0};

    // Reset state
    #2;
    check_zero("por");
    check("por_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("por_in_ready", in_ready, 1);

    // FIPS-197 C.1 with latency checks
    cm_lat = 5;
    cm_key_q.push_back(K_FIPS);
    cm_pt_q.push_back(P_FIPS);
    for (int w = 0; w < 4; w++) exp_q.push_back(C_FIPS[127 - 32*w -: 32]);
    feed_words(K_FIPS, P_FIPS, 0, 0, 3);
    check("ld_after_4th_word", aes_ld, 1);
    check("busy_in_load", busy, 1);
    repeat (5) @(posedge clk);
    #1;
    check("out_valid_on_done_cycle", out_valid, 0);
    @(posedge clk); #1;
    check("out_valid_after_done", out_valid, 1);
    drain(4, 0);
    check("fips_blk_cnt", blk_cnt, 1);

    // Table of vectors with assorted gaps and stalls
    cm_lat = 8;
    for (int i = 0; i < 4; i++) begin
      queue_block(vecs[i].key, vecs[i].pt, vecs[i].ct);
      run_stream(vecs[i].gap_pct, vecs[i].stall_pct);
    end
    check("table_blk_cnt", blk_cnt, blk_exp);

    // Back-to-back, continuous valid and ready
    do_reset("rst_b2b");
    cm_lat = 3;
    queue_block(K_FIPS, P_FIPS, C_FIPS);
    queue_block(K_ECB, P_ECB, C_ECB);
    run_stream(0, 0);
    check("b2b_blk_cnt", blk_cnt, 2);

    // Partial block persists while in_valid is low
    cm_key_q.push_back(K_ECB);
    cm_pt_q.push_back(P_ECB);
    for (int w = 0; w < 4; w++) exp_q.push_back(C_ECB[127 - 32*w -: 32]);
    feed_words(K_ECB, P_ECB, 0, 0, 0);
    check("busy_partial", busy, 1);
    repeat (6) @(posedge clk);
    #1;
    check("busy_partial_hold", busy, 1);
    check("no_ld_partial", aes_ld, 0);
    feed_words(K_ECB, P_ECB, 0, 1, 3);
    drain(4, 30);

    // Randomised blocks against the model
    cm_rand = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      queue_block(rk, rp, cipher_fn(rk, rp));
    end
    run_stream(30, 30);
    cm_rand = 1'b0;
    check("random_blk_cnt", blk_cnt, blk_exp);

    // Timeout: cipher never answers
    cm_dead = 1'b1;
    cm_key_q.push_back(K_FIPS);
    cm_pt_q.push_back(P_FIPS);
    feed_words(K_FIPS, P_FIPS, 0, 0, 3);
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (out_valid !== 1'b0) check("timeout_no_out_valid", out_valid, 0);
    end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_in_ready", in_ready, 1);
    check("timeout_busy", busy, 0);
    check("timeout_blk_cnt", blk_cnt, blk_exp);
    repeat (3) @(posedge clk);
    #1;
    check("timeout_out_valid", out_valid, 0);
    cm_dead = 1'b0;
    cm_lat = 6;
    queue_block(K_ECB, P_ECB, C_ECB);
    run_stream(0, 0);
    check("err_sticky", err, 1);

    // Done on the watchdog expiry edge wins
    do_reset("rst_done_wins");
    cm_lat = TIMEOUT - 1;
    queue_block(K_ECB, P_ECB, C_ECB);
    run_stream(0, 0);
    check("done_wins_err", err, 0);

    // Reset during WAIT
    cm_lat = 20;
    cm_key_q.push_back(K_FIPS);
    cm_pt_q.push_back(P_FIPS);
    feed_words(K_FIPS, P_FIPS, 0, 0, 3);
    repeat (3) @(posedge clk);
    do_reset("rst_wait");
    cm_lat = 4;
    queue_block(K_FIPS, P_FIPS, C_FIPS);
    run_stream(0, 0);

    // Reset in DRAIN after the first word
    cm_key_q.push_back(K_ECB);
    cm_pt_q.push_back(P_ECB);
    feed_words(K_ECB, P_ECB, 0, 0, 3);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_reached", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_word1", out_data, C_ECB[95:64]);
    do_reset("rst_drain");
    queue_block(K_ECB, P_ECB, C_ECB);
    run_stream(20, 40);
    check("after_rst_blk_cnt", blk_cnt, 1);

    // Block counter wrap
    force dut.blk_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.blk_cnt;
    @(posedge clk); #1;
    check("blk_cnt_preload", blk_cnt, 16'hFFFF);
    blk_exp = 16'hFFFF;
    queue_block(K_FIPS, P_FIPS, C_FIPS);
    run_stream(0, 0);
    check("blk_cnt_wrap", blk_cnt, 16'h0000);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Word-stream front end for aes_cipher_top; sits directly upstream of the cipher and consumes its result.
- Packs four 32-bit plaintext words into a 128-bit block, issues a one-cycle load to the cipher with the latched key, and waits for the cipher's done.
- Captures the 128-bit ciphertext and streams it back out as four 32-bit words over a valid/ready interface.
- One block in flight at a time (no overlap); a watchdog flags a cipher that never completes.

Parameters:
- TIMEOUT, 64, max cycles waiting for aes_done after aes_ld before error abort (must be >= 16).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- key  input  128  cipher key; sampled on the cycle the 4th input word is accepted.
- in_data  input  32  plaintext word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  controller accepts a word this cycle.
- out_data  output  32  ciphertext word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- aes_ld  output  1  one-cycle load strobe to the cipher.
- aes_key  output  128  key to the cipher.
- aes_text_in  output  128  assembled plaintext block to the cipher.
- aes_text_out  input  128  cipher result.
- aes_done  input  1  cipher completion pulse.
- busy  output  1  high in any state other than FILL with word count 0.
- err  output  1  sticky timeout flag; cleared only by reset.
- blk_cnt  output  16  count of blocks fully drained; wraps at 0xFFFF->0.

Behaviour:
- Reset (rst=0, async): state=FILL, word count=0.
  - in_ready=1 once reset is released; all other outputs 0, including aes_text_in/aes_key/out_data, err and blk_cnt.
- Word order is big-endian throughout:
  - Input word 0 -> aes_text_in[127:96], word 3 -> [31:0].
  - Output word 0 = captured[127:96], word 3 = captured[31:0].
- FILL:
  - in_ready=1; a handshake (in_valid&in_ready) stores the word and increments the count.
  - On the 4th handshake: latch key into aes_key, go to LOAD.
  - in_valid low: hold; partial blocks persist indefinitely.
- LOAD (exactly 1 cycle):
  - aes_ld=1 (registered); aes_text_in/aes_key stable; clear watchdog; go to WAIT.
  - in_ready=0 in LOAD, WAIT and DRAIN.
- WAIT:
  - aes_ld=0; aes_text_in/aes_key held stable until the next LOAD.
  - Watchdog increments each cycle.
  - aes_done=1: capture aes_text_out into the output buffer in that same edge, go to DRAIN.
  - aes_done in any other state is ignored.
- Timeout: watchdog reaching TIMEOUT without aes_done sets err=1 and returns to FILL, count=0. The block is discarded, no output, blk_cnt unchanged.
- DRAIN:
  - out_valid=1; out_data = current word, index 0..3.
  - Advance on out_valid&out_ready; out_data must stay stable while out_ready=0.
  - On the 4th handshake: out_valid deasserts the next cycle, blk_cnt+1, return to FILL (count=0, in_ready=1 that next cycle).
- Latency: 4th input handshake at edge N -> aes_ld high in cycle N+1 -> first out_valid in the cycle after the edge sampling aes_done.
  - With aes_cipher_top, this gives a minimum of 4 input cycles + 1 + cipher latency + 4 output cycles per block.
- Simultaneous events:
  - No input accepted during DRAIN, so there are no input/output collisions.
  - aes_done on the same edge the watchdog reaches TIMEOUT: done wins, no err.
- Reset mid-operation (any state): immediate return to reset values. Partial words and captured data are lost; aes_ld is forced low asynchronously.

Test Plan:
- FIPS-197 C.1 with real aes_cipher_top: key=000102030405060708090a0b0c0d0e0f, words 00112233,44556677,8899aabb,ccddeeff -> out words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a; blk_cnt=1; aes_ld high exactly 1 cycle.
- SP800-38A ECB: key=2b7e151628aed2a6abf7158809cf4f3c, pt=6bc1bee22e409f96e93d7e117393172a, sent with random in_valid gaps and random out_ready stalls -> 3ad77bb4,0d7a3660,a89ecaf3,2466ef97; out_data stable during each stall.
- Back-to-back: both vectors above streamed continuously with in_valid=1 and out_ready=1 -> both outputs correct in order; in_ready=0 from LOAD until the cycle after the 4th output handshake; blk_cnt=2.
- Timeout: model cipher never asserts aes_done, TIMEOUT=64 -> err=1 64 cycles after aes_ld; state FILL, no out_valid, blk_cnt unchanged; next block with a working model still completes, err stays 1.
- Reset mid-operation: drive rst=0 during WAIT and again mid-DRAIN after word 1 -> all outputs 0 immediately; after release, a fresh 4-word block produces correct output with no leftover words.
- Wrap: preload blk_cnt to 0xFFFF via force, drain one block -> blk_cnt=0x0000.
